aes256_key_expander: RTL and testbench

- Sequential AES-256 key-schedule unit, directly upstream of the combinational decryption block.
- Expands a 256-bit cipher key into round keys 1..14: 14 x 128 bits, 1792 bits total.
- These drive the decryption block's round-key bus.
- Computes one 32-bit schedule word per clock with a single shared 4-byte S-box. This replaces the precomputed constant round-key bus.

---
 rtl/aes256_key_expander.sv | 121 ++++++++++++
 tb/tb_aes256_key_expander.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_key_expander.sv
// AES-256 key schedule: expands a 256-bit key into round keys 1..14, one word per clock.
// Optional macro KEYEXP_RESTART_EN: start while busy restarts the expansion with the new key.
module aes256_key_expander #(
  parameter int NR  = 14,
  parameter int RKW = 128 * NR
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [255:0]   key,
  output logic           busy,
  output logic           done,
  output logic           keys_valid,
  output logic [RKW-1:0] round_keys
);

  // state    | meaning
  // S_IDLE   | no schedule requested since reset
  // S_RUN    | writing one schedule word (w8..w59) per clock
  // S_DONE   | schedule complete, waiting for a new start
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int          LAST   = 4 * NR + 3;
  localparam logic [5:0]  LAST_W = 6'(LAST);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [31:0] win [8];
  logic        accept;
  logic        last_word;
  logic [31:0] prev, sub_in, sub_out, t_word, new_word;
  logic [7:0]  rcon;

`ifdef KEYEXP_RESTART_EN
  assign accept = start;
`else
  assign accept = start && (state != S_RUN);
`endif

  assign busy      = (state == S_RUN);
  assign last_word = (state == S_RUN) && (cnt == LAST_W) && !accept;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN:   if (!accept && cnt == LAST_W) state_nx = S_DONE;
      S_DONE:  if (accept) state_nx = S_RUN;
      default: state_nx = S_IDLE;
    endcase
  end

  // win[0] = w[i-8] ... win[7] = w[i-1]; a single S-box set serves both substitution cases
  always_comb begin
    prev    = win[7];
    sub_in  = (cnt[2:0] == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out = sub_word(sub_in);
    rcon    = 8'h01 << (cnt[5:3] - 3'd1);
    case (cnt[2:0])
      3'd0:    t_word = sub_out ^ {rcon, 24'h0};
      3'd4:    t_word = sub_out;
      default: t_word = prev;
    endcase
    new_word = win[0] ^ t_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 6'd8;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      round_keys <= '0;
      for (int k = 0; k < 8; k++) win[k] <= '0;
    end else begin
      state <= state_nx;
      done  <= last_word;
      if (accept) begin
        cnt                     <= 6'd8;
        keys_valid              <= 1'b0;
        round_keys[RKW-1 -: 128] <= key[127:0];
        for (int k = 0; k < 8; k++) win[k] <= key[255-32*k -: 32];
      end else if (state == S_RUN) begin
        cnt <= cnt + 6'd1;
        for (int k = 0; k < 7; k++) win[k] <= win[k+1];
        win[7] <= new_word;
        for (int j = 8; j <= LAST; j++)
          if (cnt == 6'(j)) round_keys[RKW-1-32*(j-4) -: 32] <= new_word;
        if (cnt == LAST_W) keys_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes256_key_expander.sv
// Bench for aes256_key_expander: FIPS-style reference schedule model plus per-cycle output compare.
// Follows KEYEXP_RESTART_EN when it is defined for the build.
module tb_aes256_key_expander;

`ifdef KEYEXP_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [255:0]  key;
  logic          busy, done, keys_valid;
  logic [1791:0] round_keys;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  aes256_key_expander dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .round_keys (round_keys)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: S-box from GF(2^8) inverse + affine map
  logic [7:0] sbox_tbl [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tbl[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
  endfunction

  // textbook AES-256 key expansion; result holds w0..w59, w0 in the top bits
  function automatic logic [1919:0] expand(input logic [255:0] k);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] r;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 60; i++) r[1919-32*i -: 32] = w[i];
    return r;
  endfunction

  // ---------------- cycle-level expectation of the outputs
  logic          mdl_busy, mdl_done, mdl_kv;
  logic [1791:0] mdl_bus;
  logic [1919:0] mdl_sched;
  int            mdl_k;

  always @(posedge clk) begin
    if (!rst_n) begin
      mdl_busy <= 1'b0;
      mdl_done <= 1'b0;
      mdl_kv   <= 1'b0;
      mdl_bus  <= '0;
      mdl_k    <= 0;
    end else begin
      mdl_done <= 1'b0;
      if (start && (!mdl_busy || RESTART)) begin
        mdl_sched            <= expand(key);
        mdl_bus[1791 -: 128] <= key[127:0];
        mdl_busy             <= 1'b1;
        mdl_kv               <= 1'b0;
        mdl_k                <= 0;
      end else if (mdl_busy) begin
        mdl_bus[1791-32*(mdl_k+4) -: 32] <= mdl_sched[1791-32*(mdl_k+4) -: 32];
        mdl_k <= mdl_k + 1;
        if (mdl_k == 51) begin
          mdl_busy <= 1'b0;
          mdl_done <= 1'b1;
          mdl_kv   <= 1'b1;
        end
      end
    end
  end

  // ---------------- comparison helpers
  task automatic cmp_val(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_bus(input string name, input logic [1791:0] act, input logic [1791:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      for (int i = 1; i <= 14; i++)
        if (act[1791-128*(i-1) -: 128] !== exp[1791-128*(i-1) -: 128]) begin
          $display("FAIL %s: RK%0d got %h expected %h at %0t", name, i,
                   act[1791-128*(i-1) -: 128], exp[1791-128*(i-1) -: 128], $time);
          break;
        end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_val("busy", 128'(busy), 128'(mdl_busy));
      cmp_val("done", 128'(done), 128'(mdl_done));
      cmp_val("keys_valid", 128'(keys_valid), 128'(mdl_kv));
      cmp_bus("round_keys", round_keys, mdl_bus);
    end
  end

  // ---------------- stimulus
  function automatic logic [255:0] rand_key();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic pulse(input logic [255:0] k);
    start = 1'b1;
    key   = k;
    @(negedge clk);
    start = 1'b0;
    key   = rand_key();
  endtask

  task automatic wait_done(input string name, input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    int            n;
    bit            saw_done;
    logic [255:0]  ka, kb;
    logic [1919:0] full;
    int            hit;

    rst_n = 1'b0;
    start = 1'b1;
    key   = rand_key();
    init_sbox();
    cmp_val("sbox_00", 128'(sbox_tbl[8'h00]), 128'h63);
    cmp_val("sbox_01", 128'(sbox_tbl[8'h01]), 128'h7c);
    cmp_val("sbox_53", 128'(sbox_tbl[8'h53]), 128'hed);
    chk_en = 1'b1;

    repeat (3) @(negedge clk);
    cmp_val("reset_busy", 128'(busy), 128'h0);
    cmp_bus("reset_bus", round_keys, '0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);

    // reference-key expansion with literal pins
    pulse(FIPS_KEY);
    wait_done("fips_done", 100, n);
    cmp_val("fips_latency", 128'(n), 128'd52);
    cmp_val("fips_kv", 128'(keys_valid), 128'h1);
    cmp_val("fips_rk1", round_keys[1791 -: 128], 128'h101112131415161718191a1b1c1d1e1f);
    cmp_val("fips_rk2", round_keys[1663 -: 128], 128'ha573c29fa176c498a97fce93a572c09c);
    cmp_val("fips_rk14", round_keys[127:0], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    full = expand(FIPS_KEY);
    cmp_bus("fips_bus", round_keys, full[1791:0]);
    @(negedge clk);

    // second start at cycle 20 of a run
    ka = rand_key();
    kb = rand_key();
    pulse(ka);
    n = 0;
    while (!done && n < 150) begin
      start = (n == 19);
      key   = (n == 19) ? kb : rand_key();
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    cmp_val("busy_start_latency", 128'(n), RESTART ? 128'd72 : 128'd52);
    full = expand(RESTART ? kb : ka);
    cmp_bus("busy_start_bus", round_keys, full[1791:0]);

    // immediate restart from DONE with the all-zero key
    pulse('0);
    cmp_val("b2b_kv_drop", 128'(keys_valid), 128'h0);
    wait_done("b2b_done", 100, n);
    cmp_val("b2b_latency", 128'(n), 128'd52);
    cmp_val("b2b_rk1", round_keys[1791 -: 128], 128'h0);
    cmp_val("b2b_rk2", round_keys[1663 -: 128], 128'h62636363626363636263636362636363);
    @(negedge clk);

    // reset in the middle of a run
    pulse(rand_key());
    for (int c = 0; c < 30; c++) begin
      rst_n = (c != 29);
      @(negedge clk);
    end
    rst_n = 1'b1;
    cmp_val("midrst_busy", 128'(busy), 128'h0);
    cmp_bus("midrst_bus", round_keys, '0);
    saw_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    cmp_val("midrst_no_done", 128'(saw_done), 128'h0);
    ka = rand_key();
    pulse(ka);
    wait_done("after_rst_done", 100, n);
    cmp_val("after_rst_latency", 128'(n), 128'd52);
    full = expand(ka);
    cmp_bus("after_rst_bus", round_keys, full[1791:0]);

    // random keys with a stray start somewhere in each run
    for (int it = 0; it < 6; it++) begin
      pulse(rand_key());
      hit = $urandom_range(1, 60);
      n = 0;
      while (!done && n < 200) begin
        start = (n == hit);
        key   = rand_key();
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      if (!done) begin
        n_cmp++;
        n_err++;
        $display("FAIL rand_done: no done within 200 cycles");
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
